memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit.sv | 102 ++++++++++
 tb/tb_memory_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// Word-addressed RAM behind a read/write strobe with MFC handshake.
// Fixed wait-state count before each access completes.
module memory_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] dataIn,
  input  logic        read,
  input  logic        write,
  output logic [15:0] dataOut,
  output logic        MFC,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]       mem [2**ADDR_W];
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              wr_q;

  logic req_one;
  logic req_both;
  logic strobe;
  logic access;

  assign req_one  = read ^ write;
  assign req_both = read & write;
  assign strobe   = read | write;
  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign busy     = (state != IDLE);

  generate
    if (ADDR_W < 16) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^address[15:ADDR_W];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_one) state_nxt = WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = DONE;
      DONE: if (!strobe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      wr_q    <= 1'b0;
      MFC     <= 1'b0;
      error   <= 1'b0;
      dataOut <= 16'h0000;
    end else begin
      error <= (state == IDLE) && req_both;
      if ((state == IDLE) && req_one) begin
        addr_q <= address[ADDR_W-1:0];
        data_q <= dataIn;
        wr_q   <= write;
        cnt    <= WAIT_CYCLES[3:0];
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        MFC <= 1'b1;
        if (!wr_q) dataOut <= mem[addr_q];
      end else if ((state == DONE) && !strobe) begin
        MFC <= 1'b0;
      end
    end
  end

  // Storage is never cleared; a reset mid-WAIT leaves state IDLE so no commit.
  always_ff @(posedge clock) begin
    if (access && wr_q) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_memory_unit.sv
// Directed checks for memory_unit: latency, wrap, error,
// reset abort, held strobes and zero-wait back-to-back.
module tb_memory_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] address, dataIn, dataOut;
  logic        read, write, MFC, busy, error;
  logic [15:0] address0, dataIn0, dataOut0;
  logic        read0, write0, MFC0, busy0, error0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q;

  memory_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .dataIn  (dataIn),
    .read    (read),
    .write   (write),
    .dataOut (dataOut),
    .MFC     (MFC),
    .busy    (busy),
    .error   (error)
  );

  memory_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clock   (clock),
    .reset   (reset),
    .address (address0),
    .dataIn  (dataIn0),
    .read    (read0),
    .write   (write0),
    .dataOut (dataOut0),
    .MFC     (MFC0),
    .busy    (busy0),
    .error   (error0)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic xact(input string tag,
                      input bit wr,
                      input logic [15:0] a,
                      input logic [15:0] d,
                      input int hold,
                      input bit drop,
                      output logic [15:0] res);
    int lat;
    address = a;
    dataIn  = d;
    read    = !wr;
    write   = wr;
    step();
    lat = 0;
    check({tag, "_busy"}, 16'(busy), 16'h1);
    address = ~a;
    dataIn  = ~d;
    if (drop) begin
      read  = 1'b0;
      write = 1'b0;
    end
    while (!MFC && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 16'(lat), 16'd3);
    res = dataOut;
    for (int i = 0; i < hold; i++) begin
      dataIn = dataIn + 16'h0101;
      step();
      check({tag, "_hold_mfc"}, 16'(MFC), 16'h1);
      check({tag, "_hold_dout"}, dataOut, res);
    end
    read  = 1'b0;
    write = 1'b0;
    step();
    check({tag, "_mfc_low"}, 16'(MFC), 16'h0);
    check({tag, "_idle"}, 16'(busy), 16'h0);
  endtask

  initial begin
    reset    = 1'b1;
    address  = 16'h0;
    dataIn   = 16'h0;
    read     = 1'b0;
    write    = 1'b0;
    address0 = 16'h0;
    dataIn0  = 16'h0;
    read0    = 1'b0;
    write0   = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_mfc", 16'(MFC), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_err", 16'(error), 16'h0);
    check("rst_dout", dataOut, 16'h0);
    step();
    reset = 1'b1;

    xact("w10", 1, 16'h0010, 16'h5555, 0, 0, q);
    xact("w05", 1, 16'h0005, 16'hBEEF, 0, 0, q);
    xact("r05", 0, 16'h0005, 16'h0000, 0, 0, q);
    check("r05_data", q, 16'hBEEF);

    xact("w103", 1, 16'h0103, 16'h1234, 0, 0, q);
    check("w_keeps_dout", dataOut, 16'hBEEF);
    xact("r003", 0, 16'h0003, 16'h0000, 1, 0, q);
    check("wrap_data", q, 16'h1234);

    read    = 1'b1;
    write   = 1'b1;
    address = 16'h0003;
    dataIn  = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      check("both_err", 16'(error), 16'h1);
      check("both_mfc", 16'(MFC), 16'h0);
      check("both_busy", 16'(busy), 16'h0);
      check("both_dout", dataOut, 16'h1234);
    end
    read  = 1'b0;
    write = 1'b0;
    step();
    check("both_err_clr", 16'(error), 16'h0);
    xact("r003b", 0, 16'h0003, 16'h0000, 0, 0, q);
    check("both_ram", q, 16'h1234);

    xact("w20", 1, 16'h0020, 16'h1111, 3, 0, q);
    xact("r20", 0, 16'h0020, 16'h0000, 0, 0, q);
    check("once_data", q, 16'h1111);

    xact("rab", 0, 16'h0005, 16'h0000, 0, 1, q);
    check("abandon_data", q, 16'hBEEF);

    address = 16'h0010;
    dataIn  = 16'hAAAA;
    write   = 1'b1;
    step();
    step();
    check("rw_inwait", 16'(busy), 16'h1);
    reset = 1'b0;
    #1;
    check("rw_mfc", 16'(MFC), 16'h0);
    check("rw_busy", 16'(busy), 16'h0);
    check("rw_err", 16'(error), 16'h0);
    check("rw_dout", dataOut, 16'h0);
    write = 1'b0;
    step();
    reset = 1'b1;
    xact("r10", 0, 16'h0010, 16'h0000, 0, 0, q);
    check("abort_ram", q, 16'h5555);

    address0 = 16'h0007;
    dataIn0  = 16'h0F0F;
    write0   = 1'b1;
    step();
    check("z_w_busy", 16'(busy0), 16'h1);
    check("z_w_mfc0", 16'(MFC0), 16'h0);
    step();
    check("z_w_mfc1", 16'(MFC0), 16'h1);
    check("z_w_busy2", 16'(busy0), 16'h1);
    write0 = 1'b0;
    step();
    check("z_w_done", 16'(MFC0), 16'h0);
    check("z_w_idle", 16'(busy0), 16'h0);
    read0 = 1'b1;
    step();
    check("z_r_busy", 16'(busy0), 16'h1);
    check("z_r_mfc0", 16'(MFC0), 16'h0);
    step();
    check("z_r_mfc1", 16'(MFC0), 16'h1);
    check("z_r_data", dataOut0, 16'h0F0F);
    read0 = 1'b0;
    step();
    check("z_r_done", 16'(MFC0), 16'h0);
    check("z_r_idle", 16'(busy0), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
